five_bit_adder_sequencer: RTL and testbench

//  Upstream operand sequencer for the 5-bit ripple adder on the lab board.
//  It latches operand X and then operand Y from 5 slide switches, using debounced pushbutton presses.
//  It drives both operands to the adder, then registers the adder's {carry, sum} into a held 6-bit result.
//  Its outputs feed the adder inputs and the board LEDs.

---
 rtl/five_bit_adder_sequencer.sv | 146 ++++++++++++++
 tb/tb_five_bit_adder_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/five_bit_adder_sequencer.sv
// Operand sequencer for the lab-board 5-bit ripple adder: debounces two buttons,
// latches X then Y from the switches, and captures the adder's {carry, sum}.
module five_bit_adder_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic        CIN_VALUE       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [4:0] adder_x,
    output logic [4:0] adder_y,
    output logic       adder_cin,
    input  logic [4:0] adder_z,
    input  logic       adder_carry,
    output logic [5:0] result,
    output logic       result_valid,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_LOAD_X = 2'b00,
        S_LOAD_Y = 2'b01,
        S_SAMPLE = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // Index 0 is the load button, index 1 the clear button.
    logic [1:0]       btn_raw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];

    logic             load_p;
    logic             clear_p;

    state_t           state, state_nxt;
    logic [4:0]       x_reg, x_nxt;
    logic [4:0]       y_reg, y_nxt;
    logic [5:0]       result_nxt;
    logic             valid_nxt;

    assign btn_raw = {btn_clear, btn_load};
    assign load_p  = press[0];
    assign clear_p = press[1];

    // Input conditioning: 2-flop sync, stability counter, rising-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    cnt[i]   <= '0;
                    deb[i]   <= ~deb[i];
                    press[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequencer state and operand/result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LOAD_X;
            x_reg        <= '0;
            y_reg        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            x_reg        <= x_nxt;
            y_reg        <= y_nxt;
            result       <= result_nxt;
            result_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_reg;
        y_nxt      = y_reg;
        result_nxt = result;
        valid_nxt  = result_valid;
        if (clear_p) begin
            state_nxt  = S_LOAD_X;
            x_nxt      = '0;
            y_nxt      = '0;
            result_nxt = '0;
            valid_nxt  = 1'b0;
        end else begin
            case (state)
                S_LOAD_X: begin
                    if (load_p) begin
                        x_nxt     = sw;
                        state_nxt = S_LOAD_Y;
                    end
                end
                S_LOAD_Y: begin
                    if (load_p) begin
                        y_nxt     = sw;
                        state_nxt = S_SAMPLE;
                    end
                end
                // Operands have been stable for a full cycle; adder output is settled.
                S_SAMPLE: begin
                    result_nxt = {adder_carry, adder_z};
                    valid_nxt  = 1'b1;
                    state_nxt  = S_DONE;
                end
                S_DONE: begin
                    if (load_p) begin
                        x_nxt     = sw;
                        valid_nxt = 1'b0;
                        state_nxt = S_LOAD_Y;
                    end
                end
                default: state_nxt = S_LOAD_X;
            endcase
        end
    end

    assign adder_x   = x_reg;
    assign adder_y   = y_reg;
    assign adder_cin = CIN_VALUE;
    assign state_dbg = state;

endmodule

// File: tb/tb_five_bit_adder_sequencer.sv
// Directed bench for five_bit_adder_sequencer with a behavioural 5-bit adder
// closing the loop between adder_x/adder_y and adder_z/adder_carry.
module tb_five_bit_adder_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] sw;
    logic       btn_load;
    logic       btn_clear;
    logic [4:0] adder_x;
    logic [4:0] adder_y;
    logic       adder_cin;
    logic [4:0] adder_z;
    logic       adder_carry;
    logic [5:0] result;
    logic       result_valid;
    logic [1:0] state_dbg;

    int errs   = 0;
    int checks = 0;

    five_bit_adder_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CIN_VALUE      (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .btn_load    (btn_load),
        .btn_clear   (btn_clear),
        .adder_x     (adder_x),
        .adder_y     (adder_y),
        .adder_cin   (adder_cin),
        .adder_z     (adder_z),
        .adder_carry (adder_carry),
        .result      (result),
        .result_valid(result_valid),
        .state_dbg   (state_dbg)
    );

    assign {adder_carry, adder_z} = {1'b0, adder_x} + {1'b0, adder_y} + {5'b0, adder_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Clean press held long enough to debounce, then a clean release.
    task automatic load_op(input logic [4:0] v);
        sw = v;
        @(negedge clk) btn_load = 1'b1;
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_op();
        @(negedge clk) btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Y load with cycle-exact checks: pulse acts on edge 8 after the press,
    // result lands on edge 9.
    task automatic y_load_checked(input string tag, input logic [4:0] v, input int exp_res);
        sw = v;
        @(negedge clk) btn_load = 1'b1;
        repeat (7) @(negedge clk);
        chk({tag, "_state_pre"}, int'(state_dbg), 1);
        @(negedge clk);
        chk({tag, "_state_sample"}, int'(state_dbg), 2);
        chk({tag, "_y"}, int'(adder_y), int'(v));
        chk({tag, "_valid_pre"}, int'(result_valid), 0);
        @(negedge clk);
        chk({tag, "_result"}, int'(result), exp_res);
        chk({tag, "_valid"}, int'(result_valid), 1);
        chk({tag, "_state_done"}, int'(state_dbg), 3);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        sw        = '0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_x", int'(adder_x), 0);
        chk("rst_y", int'(adder_y), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("cin", int'(adder_cin), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic add 9 + 12
        load_op(5'd9);
        chk("t2_x", int'(adder_x), 9);
        chk("t2_state", int'(state_dbg), 1);
        y_load_checked("t2", 5'd12, 21);

        // Re-run from S_DONE
        load_op(5'd3);
        chk("t6_valid", int'(result_valid), 0);
        chk("t6_x", int'(adder_x), 3);
        chk("t6_state", int'(state_dbg), 1);
        chk("t6_result_held", int'(result), 21);

        // Overflow cases after a clear
        clear_op();
        chk("clr_state", int'(state_dbg), 0);
        chk("clr_result", int'(result), 0);
        chk("clr_y", int'(adder_y), 0);
        load_op(5'd31);
        y_load_checked("t3a", 5'd31, 62);
        load_op(5'd31);
        y_load_checked("t3b", 5'd1, 32);

        // 3-cycle glitch must be ignored
        sw = 5'd7;
        @(negedge clk) btn_load = 1'b1;
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_glitch_state", int'(state_dbg), 3);
        chk("t4_glitch_valid", int'(result_valid), 1);

        // Bouncy press, then settles high: single pulse 7 cycles after settle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) btn_load = ~btn_load;
        end
        @(negedge clk) btn_load = 1'b1;
        repeat (7) @(negedge clk);
        chk("t4_bounce_pre", int'(state_dbg), 3);
        @(negedge clk);
        chk("t4_bounce_state", int'(state_dbg), 1);
        chk("t4_bounce_x", int'(adder_x), 7);
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_single_pulse", int'(state_dbg), 1);

        // Async reset in the middle of S_SAMPLE
        sw = 5'd6;
        @(negedge clk) btn_load = 1'b1;
        repeat (8) @(negedge clk);
        chk("t1_in_sample", int'(state_dbg), 2);
        chk("t1_old_result", int'(result), 32);
        reset    = 1'b1;
        btn_load = 1'b0;
        #2;
        chk("t1_state", int'(state_dbg), 0);
        chk("t1_x", int'(adder_x), 0);
        chk("t1_y", int'(adder_y), 0);
        chk("t1_result", int'(result), 0);
        chk("t1_valid", int'(result_valid), 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clear in S_LOAD_Y, then simultaneous clear and load
        load_op(5'd4);
        chk("t5_pre_state", int'(state_dbg), 1);
        clear_op();
        chk("t5_state", int'(state_dbg), 0);
        chk("t5_x", int'(adder_x), 0);
        sw = 5'd13;
        @(negedge clk) begin
            btn_load  = 1'b1;
            btn_clear = 1'b1;
        end
        repeat (10) @(negedge clk);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_both_state", int'(state_dbg), 0);
        chk("t5_both_x", int'(adder_x), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
